// File: rtl/fcpu_pkg.sv
// rtl/fcpu_pkg.sv - core-wide CDB word layout and arbitration mode constants
package fcpu_pkg;

    localparam int RSV_ID_W = 6;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rsv_id;
        logic [DATA_W-1:0]   data;
    } cdb_t;

    localparam bit CDB_ARB_FIXED = 1'b0;
    localparam bit CDB_ARB_RR    = 1'b1;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - unit result slots and CDB broadcast bundle
interface cdb_arbiter_if #(
    parameter int N_UNITS = 2,
    parameter int CDB_W   = fcpu_pkg::CDB_W
);

    logic [N_UNITS-1:0][CDB_W-1:0] units_cdb;
    logic [N_UNITS-1:0]            units_cdb_valid;
    logic [N_UNITS-1:0]            units_cdb_ready;
    logic                          flush;
    logic [CDB_W-1:0]              cdb;
    logic                          cdb_valid;
    logic [N_UNITS-1:0]            cdb_grant;
    logic [N_UNITS-1:0]            pending;

    modport master (
        output units_cdb,
        output units_cdb_valid,
        output flush,
        input  units_cdb_ready,
        input  cdb,
        input  cdb_valid,
        input  cdb_grant,
        input  pending
    );

    modport slave (
        input  units_cdb,
        input  units_cdb_valid,
        input  flush,
        output units_cdb_ready,
        output cdb,
        output cdb_valid,
        output cdb_grant,
        output pending
    );

endinterface

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - N-way one-hot selector searching upward from a start index with wrap
module rr_priority_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Two passes: indices at or above start first, then the wrapped-around low indices.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any_o && req_i[j] && (j >= int'(start_i))) begin
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
                any_o    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any_o && req_i[j] && (j < int'(start_i))) begin
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common-data-bus arbiter with per-unit holding slots and flush
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_UNITS = 2,
    parameter int CDB_W   = fcpu_pkg::CDB_W,
    parameter bit ARB_RR  = CDB_ARB_RR,
    parameter bit OUT_REG = 1'b1
) (
    input  logic          clk,
    input  logic          nrst,
    cdb_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(N_UNITS);

    logic [N_UNITS-1:0]            occ_q, occ_d;
    logic [N_UNITS-1:0][CDB_W-1:0] word_q, word_d;
    logic [PTR_W-1:0]              ptr_q, ptr_d;

    logic [N_UNITS-1:0] req;
    logic [N_UNITS-1:0] gnt;
    logic [N_UNITS-1:0] ready;
    logic [N_UNITS-1:0] accept;
    logic [PTR_W-1:0]   start;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [CDB_W-1:0]   sel_word;

    assign start = ARB_RR ? ptr_q : '0;
    assign req   = occ_q & ~{N_UNITS{bus.flush}};

    rr_priority_select #(
        .N     (N_UNITS),
        .IDX_W (PTR_W)
    ) u_sel (
        .req_i   (req),
        .start_i (start),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // A granted slot frees itself this cycle, so a streaming unit can reload without a bubble.
    assign ready  = ~{N_UNITS{bus.flush}} & (~occ_q | gnt);
    assign accept = bus.units_cdb_valid & ready;

    assign bus.units_cdb_ready = ready;
    assign bus.pending         = occ_q;

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (gnt[i]) begin
                sel_word = sel_word | word_q[i];
            end
        end
    end

    always_comb begin
        occ_d  = occ_q;
        word_d = word_q;
        ptr_d  = ptr_q;
        if (bus.flush) begin
            occ_d = '0;
        end else begin
            occ_d = (occ_q & ~gnt) | accept;
        end
        for (int i = 0; i < N_UNITS; i++) begin
            if (accept[i]) begin
                word_d[i] = bus.units_cdb[i];
            end
        end
        if (ARB_RR && gnt_any) begin
            ptr_d = (gnt_idx == PTR_W'(N_UNITS - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            occ_q  <= '0;
            word_q <= '0;
            ptr_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            word_q <= word_d;
            ptr_q  <= ptr_d;
        end
    end

    // Flush blocks the grant, so the word registered in the flush cycle is already idle.
    if (OUT_REG) begin : g_out_reg
        logic [CDB_W-1:0]   cdb_q;
        logic               cdb_valid_q;
        logic [N_UNITS-1:0] cdb_grant_q;

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                cdb_q       <= '0;
                cdb_valid_q <= 1'b0;
                cdb_grant_q <= '0;
            end else begin
                cdb_q       <= sel_word;
                cdb_valid_q <= gnt_any;
                cdb_grant_q <= gnt;
            end
        end

        assign bus.cdb       = cdb_q;
        assign bus.cdb_valid = cdb_valid_q;
        assign bus.cdb_grant = cdb_grant_q;
    end else begin : g_out_comb
        assign bus.cdb       = sel_word;
        assign bus.cdb_valid = gnt_any;
        assign bus.cdb_grant = gnt;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and scoreboard checks for cdb_arbiter
module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_UNITS(N), .CDB_W(CDB_W)) bus_a ();
    cdb_arbiter_if #(.N_UNITS(N), .CDB_W(CDB_W)) bus_b ();

    cdb_arbiter #(.N_UNITS(N), .CDB_W(CDB_W), .ARB_RR(1'b1), .OUT_REG(1'b1)) dut_a (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_a)
    );

    cdb_arbiter #(.N_UNITS(N), .CDB_W(CDB_W), .ARB_RR(1'b0), .OUT_REG(1'b0)) dut_b (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_b)
    );

    int total = 0;
    int bad   = 0;

    logic [N-1:0]     acc;
    logic [N-1:0]     vld;
    int unsigned      seq  [N];
    int unsigned      rseq [N];
    logic [CDB_W-1:0] expq [N][$];

    function automatic logic [CDB_W-1:0] mk(input int id, input logic [31:0] d);
        cdb_t w;
        w.rsv_id = RSV_ID_W'(id);
        w.data   = d;
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check();
        int u;
        if (bus_a.cdb_valid === 1'b1) begin
            u = -1;
            for (int i = 0; i < N; i++) if (bus_a.cdb_grant[i]) u = i;
            check("sb_onehot", 64'($countones(bus_a.cdb_grant)), 64'd1);
            if (u >= 0) begin
                check("sb_nonempty", 64'(expq[u].size() != 0), 64'd1);
                if (expq[u].size() != 0) begin
                    check("sb_word", 64'(bus_a.cdb), 64'(expq[u].pop_front()));
                end
            end
        end
    endtask

    initial begin
        nrst = 1'b0;
        bus_a.units_cdb = '0; bus_a.units_cdb_valid = '0; bus_a.flush = 1'b0;
        bus_b.units_cdb = '0; bus_b.units_cdb_valid = '0; bus_b.flush = 1'b0;
        for (int i = 0; i < N; i++) begin seq[i] = 0; rseq[i] = 0; end
        vld = '0;
        #1;
        check("rst_valid", 64'(bus_a.cdb_valid), 64'd0);
        check("rst_pending", 64'(bus_a.pending), 64'd0);
        step();
        step();
        nrst = 1'b1;
        #1;
        check("rst_ready", 64'(bus_a.units_cdb_ready), 64'hf);

        // Round-robin saturation: all units valid, each reloading when granted.
        for (int i = 0; i < N; i++) bus_a.units_cdb[i] = mk(i, 0);
        bus_a.units_cdb_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k >= 2) begin
                check("sat_grant", 64'(bus_a.cdb_grant), 64'(1 << ((k - 2) % 4)));
                check("sat_word", 64'(bus_a.cdb), 64'(mk((k - 2) % 4, 32'((k - 2) / 4))));
            end
            if (k >= 1) check("sat_ready", 64'(bus_a.units_cdb_ready), 64'(1 << ((k - 1) % 4)));
            acc = bus_a.units_cdb_ready & bus_a.units_cdb_valid;
            step();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    bus_a.units_cdb[i] = mk(i, 32'(seq[i]));
                end
            end
        end

        // Asynchronous reset in the middle of a broadcast.
        #1;
        check("mid_valid_before", 64'(bus_a.cdb_valid), 64'd1);
        nrst = 1'b0;
        #1;
        check("arst_valid", 64'(bus_a.cdb_valid), 64'd0);
        check("arst_grant", 64'(bus_a.cdb_grant), 64'd0);
        check("arst_pending", 64'(bus_a.pending), 64'd0);
        bus_a.units_cdb_valid = '0;
        step();
        nrst = 1'b1;
        #1;
        check("arst_ready", 64'(bus_a.units_cdb_ready), 64'hf);

        // Single result from unit 2, two edges to broadcast, one cycle wide.
        bus_a.units_cdb[2] = mk(5, 32'h1234);
        bus_a.units_cdb_valid = 4'b0100;
        step();
        bus_a.units_cdb_valid = '0;
        #1;
        check("one_pending", 64'(bus_a.pending), 64'b0100);
        check("one_early", 64'(bus_a.cdb_valid), 64'd0);
        step();
        check("one_valid", 64'(bus_a.cdb_valid), 64'd1);
        check("one_word", 64'(bus_a.cdb), 64'(mk(5, 32'h1234)));
        check("one_grant", 64'(bus_a.cdb_grant), 64'b0100);
        step();
        check("one_after", 64'(bus_a.cdb_valid), 64'd0);
        check("one_after_grant", 64'(bus_a.cdb_grant), 64'd0);

        // Unit 1 streams eight words back to back.
        for (int k = 0; k < 11; k++) begin
            if (k < 8) begin
                bus_a.units_cdb[1] = mk(1, 32'(32'ha0 + k));
                bus_a.units_cdb_valid = 4'b0010;
            end else begin
                bus_a.units_cdb_valid = '0;
            end
            #1;
            if (k < 8) check("strm_ready", 64'(bus_a.units_cdb_ready[1]), 64'd1);
            if (k >= 2 && k <= 9) begin
                check("strm_valid", 64'(bus_a.cdb_valid), 64'd1);
                check("strm_word", 64'(bus_a.cdb), 64'(mk(1, 32'(32'ha0 + k - 2))));
            end else begin
                check("strm_idle", 64'(bus_a.cdb_valid), 64'd0);
            end
            step();
        end

        // Flush with slots 0 and 3 occupied; pointer now at 2 so slot 3 wins first.
        bus_a.units_cdb[0] = mk(0, 32'hf0);
        bus_a.units_cdb[3] = mk(3, 32'hf3);
        bus_a.units_cdb_valid = 4'b1001;
        step();
        bus_a.units_cdb_valid = '0;
        #1;
        check("fl_pending", 64'(bus_a.pending), 64'b1001);
        step();
        bus_a.flush = 1'b1;
        bus_a.units_cdb[0] = mk(0, 32'hdead);
        bus_a.units_cdb_valid = 4'b0001;
        #1;
        check("fl_ready", 64'(bus_a.units_cdb_ready), 64'd0);
        check("fl_prev_valid", 64'(bus_a.cdb_valid), 64'd1);
        check("fl_prev_grant", 64'(bus_a.cdb_grant), 64'b1000);
        check("fl_prev_pending", 64'(bus_a.pending), 64'b0001);
        step();
        bus_a.flush = 1'b0;
        bus_a.units_cdb_valid = '0;
        #1;
        check("fl_valid", 64'(bus_a.cdb_valid), 64'd0);
        check("fl_pending_clr", 64'(bus_a.pending), 64'd0);
        check("fl_ready_back", 64'(bus_a.units_cdb_ready), 64'hf);
        for (int k = 0; k < 3; k++) begin
            step();
            check("fl_no_bcast", 64'(bus_a.cdb_valid), 64'd0);
        end

        // Random back-pressure with per-unit in-order scoreboard.
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && ($urandom_range(0, 1) == 1)) begin
                    vld[i] = 1'b1;
                    bus_a.units_cdb[i] = mk(i, (32'(i) << 24) | 32'(rseq[i]));
                end
            end
            bus_a.units_cdb_valid = vld;
            #1;
            acc = bus_a.units_cdb_ready & bus_a.units_cdb_valid;
            step();
            sb_check();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    expq[i].push_back(bus_a.units_cdb[i]);
                    rseq[i]++;
                    vld[i] = 1'b0;
                end
            end
        end
        bus_a.units_cdb_valid = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            sb_check();
        end
        for (int i = 0; i < N; i++) check("sb_drained", 64'(expq[i].size()), 64'd0);
        check("sb_pending", 64'(bus_a.pending), 64'd0);

        // Fixed priority, combinational output: unit 0 monopolises the bus.
        bus_b.units_cdb[0] = mk(0, 0);
        for (int i = 1; i < N; i++) bus_b.units_cdb[i] = mk(i, 32'(32'hb0 + i));
        bus_b.units_cdb_valid = 4'b1111;
        #1;
        check("fx_ready0", 64'(bus_b.units_cdb_ready), 64'hf);
        check("fx_idle0", 64'(bus_b.cdb_valid), 64'd0);
        for (int k = 1; k <= 9; k++) begin
            step();
            bus_b.units_cdb[0] = mk(0, 32'(k));
            bus_b.units_cdb_valid = (k <= 4) ? 4'b0001 : 4'b0000;
            #1;
            if (k <= 5) begin
                check("fx_grant0", 64'(bus_b.cdb_grant), 64'b0001);
                check("fx_word0", 64'(bus_b.cdb), 64'(mk(0, 32'(k - 1))));
                check("fx_ready", 64'(bus_b.units_cdb_ready), 64'b0001);
            end else if (k <= 8) begin
                check("fx_grant_drain", 64'(bus_b.cdb_grant), 64'(1 << (k - 5)));
                check("fx_word_drain", 64'(bus_b.cdb), 64'(mk(k - 5, 32'(32'hb0 + k - 5))));
            end else begin
                check("fx_end_valid", 64'(bus_b.cdb_valid), 64'd0);
                check("fx_end_grant", 64'(bus_b.cdb_grant), 64'd0);
                check("fx_end_word", 64'(bus_b.cdb), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
